// File: rtl/alu_pkg.sv
// alu_pkg: ALUOp encodings, default widths and immediate-extend helper for the operand-fetch stage.
package alu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  function automatic logic [DEF_DATA_W-1:0] imm_ext(input logic [15:0] imm, input logic sext);
    return {{(DEF_DATA_W-16){imm[15] & sext}}, imm};
  endfunction
endpackage

// File: rtl/grf.sv
// grf: general register file, two bypassed combinational reads, one synchronous write, r0 fixed at zero.
module grf
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] da,
  output logic [DATA_W-1:0] db,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (we && wa != '0)
      regs[wa] <= wd;
  // Write-through so a result written this cycle is visible to the reader immediately.
  always_comb begin
    da = (ra == '0) ? '0 : (we && wa == ra) ? wd : regs[ra];
    db = (rb == '0) ? '0 : (we && wa == rb) ? wd : regs[rb];
  end
endmodule

// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: reads rs/rt, selects B, registers the operand bundle toward the ALU.
// Define ALU_OPERAND_FETCH_SCOREBOARD_EN to stall on reads of registers with results still pending.
module alu_operand_fetch
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [15:0]       in_imm,
  input  logic              in_use_imm,
  input  logic              in_imm_sext,
  input  logic [2:0]        in_aluop,
  input  logic [ADDR_W-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_aluop,
  output logic [ADDR_W-1:0] out_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);
  logic [DATA_W-1:0] rd_a, rd_b, b_sel;
  logic hazard, accept;
  grf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_grf (
    .clk(clk), .reset(reset), .ra(in_rs), .rb(in_rt), .da(rd_a), .db(rd_b),
    .we(wb_en), .wa(wb_addr), .wd(wb_data)
  );
`ifdef ALU_OPERAND_FETCH_SCOREBOARD_EN
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DEPTH-1:0] pend, clr, set, live;
  always_comb begin
    clr = wb_en ? DEPTH'(1) << wb_addr : '0;
    set = (accept && in_rd != '0) ? DEPTH'(1) << in_rd : '0;
    live = pend & ~clr;
    hazard = in_valid && (live[in_rs] || (!in_use_imm && live[in_rt]));
  end
  // Set after clear so a same-cycle set on the same index wins.
  always_ff @(posedge clk or negedge reset)
    if (!reset) pend <= '0;
    else pend <= (live | set) & ~DEPTH'(1);
`else
  assign hazard = 1'b0;
`endif
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept = in_valid && in_ready;
  assign b_sel = in_use_imm ? DATA_W'(imm_ext(in_imm, in_imm_sext)) : rd_b;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_a <= '0;
      out_b <= '0;
      out_aluop <= '0;
      out_rd <= '0;
    end else begin
      out_valid <= accept || (out_valid && !out_ready);
      if (accept) begin
        out_a <= rd_a;
        out_b <= b_sel;
        out_aluop <= in_aluop;
        out_rd <= in_rd;
      end
    end
endmodule

// File: tb/tb_alu_operand_fetch.sv
// tb_alu_operand_fetch: directed self-checking bench for alu_operand_fetch.
module tb_alu_operand_fetch;
  logic clk = 0, reset = 0;
  logic in_valid = 0, in_ready, in_use_imm = 0, in_imm_sext = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0, out_rd, wb_addr = 0;
  logic [15:0] in_imm = 0;
  logic [2:0] in_aluop = 0, out_aluop;
  logic out_valid, out_ready = 1, wb_en = 0;
  logic [31:0] out_a, out_b, wb_data = 0;
  int n_assert = 0, n_fail = 0;

  alu_operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_imm_sext(in_imm_sext), .in_aluop(in_aluop), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_aluop(out_aluop), .out_rd(out_rd), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [2:0] op);
    in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd; in_aluop = op;
  endtask

  initial begin
    step(); step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_a", out_a, 0);
    check("rst_b", out_b, 0);
    check("rst_rd", 32'(out_rd), 0);
    reset = 1;
    // Read after reset: all registers zero.
    issue(3, 4, 1, 3'b000);
    #1 check("rst_in_ready", 32'(in_ready), 1);
    step();
    check("rd0_valid", 32'(out_valid), 1);
    check("rd0_a", out_a, 0);
    check("rd0_b", out_b, 0);
    // Same-cycle write-back bypass.
    issue(5, 0, 2, 3'b001);
    wb_en = 1; wb_addr = 5; wb_data = 32'h1234_5678;
    step();
    check("byp_a", out_a, 32'h1234_5678);
    check("byp_b", out_b, 0);
    check("byp_op", 32'(out_aluop), 1);
    check("byp_rd", 32'(out_rd), 2);
    // r0 write ignored; r5 now stored.
    issue(0, 5, 3, 3'b000);
    wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    step();
    check("r0_a", out_a, 0);
    check("r5_b", out_b, 32'h1234_5678);
    wb_en = 0;
    // Immediate extension.
    issue(5, 0, 4, 3'b101);
    in_use_imm = 1; in_imm = 16'h8001; in_imm_sext = 1;
    step();
    check("sext_b", out_b, 32'hFFFF_8001);
    check("sext_op", 32'(out_aluop), 5);
    check("sext_a", out_a, 32'h1234_5678);
    in_imm_sext = 0;
    step();
    check("zext_b", out_b, 32'h0000_8001);
    in_use_imm = 0;
    // Backpressure with a write to the held rs.
    issue(5, 0, 9, 3'b010);
    step();
    check("bp_a0", out_a, 32'h1234_5678);
    out_ready = 0;
    issue(3, 0, 11, 3'b011);
    wb_en = 1; wb_addr = 5; wb_data = 32'hCAFE_BABE;
    #1 check("bp_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      wb_en = 0;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_a", out_a, 32'h1234_5678);
      check("bp_rd", 32'(out_rd), 9);
      check("bp_op", 32'(out_aluop), 2);
      check("bp_stall", 32'(in_ready), 0);
    end
    out_ready = 1;
    issue(5, 0, 10, 3'b000);
    #1 check("bp_release_ready", 32'(in_ready), 1);
    step();
    check("bp_new_valid", 32'(out_valid), 1);
    check("bp_new_a", out_a, 32'hCAFE_BABE);
    check("bp_new_rd", 32'(out_rd), 10);
    // Load r1..r8 for streaming.
    in_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      wb_en = 1; wb_addr = 5'(i); wb_data = 32'h100 + i;
      step();
    end
    wb_en = 0;
    check("idle_valid", 32'(out_valid), 0);
    for (int i = 1; i <= 8; i++) begin
      issue(5'(i), 0, 5'(i), 3'b000);
      #1 check("str_ready", 32'(in_ready), 1);
      step();
      check("str_valid", 32'(out_valid), 1);
      check("str_a", out_a, 32'h100 + i);
      check("str_rd", 32'(out_rd), i);
    end
    in_valid = 0;
    step();
    check("str_drain", 32'(out_valid), 0);
    // Pending destination r7 then a reader of r7.
    issue(0, 0, 7, 3'b000);
    step();
    issue(7, 0, 12, 3'b000);
`ifdef ALU_OPERAND_FETCH_SCOREBOARD_EN
    for (int i = 0; i < 2; i++) begin
      #1 check("sb_stall", 32'(in_ready), 0);
      step();
    end
    check("sb_bubble", 32'(out_valid), 0);
`else
    #1 check("nosb_ready", 32'(in_ready), 1);
    step();
    check("nosb_a", out_a, 32'h107);
`endif
    wb_en = 1; wb_addr = 7; wb_data = 32'h0000_0077;
    #1 check("sb_wb_ready", 32'(in_ready), 1);
    step();
    wb_en = 0;
    check("sb_wb_a", out_a, 32'h77);
    check("sb_wb_valid", 32'(out_valid), 1);
    // Asynchronous reset while a bundle is held.
    in_valid = 0; out_ready = 0;
    #2 reset = 0;
    #1 check("arst_valid", 32'(out_valid), 0);
    check("arst_a", out_a, 0);
    step();
    reset = 1; out_ready = 1;
    issue(5, 7, 1, 3'b000);
    step();
    check("arst_grf_a", out_a, 0);
    check("arst_grf_b", out_b, 0);
    in_valid = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
- Operand-fetch stage directly upstream of the EX-stage ALU.
- Accepts decoded instruction fields and reads rs/rt from an internal 32x32 general register file (GRF). Selects rt or an extended 16-bit immediate for B.
- Registers A, B, ALUOp and destination rd toward the ALU over a valid/ready handshake.
- Writes ALU/write-back results into the GRF, with same-cycle write-through bypass on reads.

Parameters:
- DATA_W, 32, operand/register width.
- ADDR_W, 5, register index width; GRF depth is 2**ADDR_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept this cycle.
- in_rs  input  ADDR_W  source register for A.
- in_rt  input  ADDR_W  source register for B when in_use_imm=0.
- in_imm  input  16  immediate field.
- in_use_imm  input  1  B takes the extended immediate instead of GRF[rt].
- in_imm_sext  input  1  1 = sign-extend, 0 = zero-extend the immediate.
- in_aluop  input  3  ALU operation code, passed through.
- in_rd  input  ADDR_W  destination register, passed through.
- out_valid  output  1  operand bundle valid toward the ALU.
- out_ready  input  1  ALU side accepts the bundle.
- out_a  output  DATA_W  operand A.
- out_b  output  DATA_W  operand B.
- out_aluop  output  3  registered ALUOp.
- out_rd  output  ADDR_W  registered destination.
- wb_en  input  1  GRF write enable.
- wb_addr  input  ADDR_W  GRF write index.
- wb_data  input  DATA_W  GRF write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0; out_a=0, out_b=0, out_aluop=0, out_rd=0.
  - All GRF entries = 0.
- Readiness and acceptance:
  - in_ready = !out_valid || out_ready (single output register, no skid).
  - Accept occurs when in_valid && in_ready. On the next edge the output register loads, out_valid=1, and latency is 1 cycle.
  - If out_valid && out_ready && !accept, out_valid clears next edge.
- Stall: while out_valid && !out_ready, out_a, out_b, out_aluop and out_rd hold stable. Operands are captured at acceptance; later GRF writes do not alter a held bundle.
- GRF read: combinational at acceptance.
  - Index 0 always reads 0.
  - Bypass: if wb_en && wb_addr==index && index!=0, the read returns wb_data, not the stale entry.
- GRF write: on the edge when wb_en=1 and wb_addr!=0. Writes to index 0 are ignored.
- B select:
  - in_use_imm=1: B = {16{in_imm[15]&in_imm_sext}, in_imm}.
  - in_use_imm=0: B = GRF[rt] (bypassed).
- No arithmetic in this block; width is preserved, with no truncation.
- Simultaneous events:
  - Write-back and accept in the same cycle are independent, and the bypass applies.
  - Write-back during a stall only updates the GRF.
- Reset mid-operation drops any held bundle; no replay.

Optional Feature:
- Macro: ALU_OPERAND_FETCH_SCOREBOARD_EN.
- Defined:
  - A 2**ADDR_W-bit pending mask resets to 0.
  - On accept with in_rd!=0, bit in_rd is set.
  - On wb_en, bit wb_addr is cleared. If the set and clear target the same index in one cycle, set wins.
  - in_ready is additionally forced 0 when in_valid && (pend[rs] || (!in_use_imm && pend[rt])). A bit being cleared by wb_en this same cycle does not count as pending, because the bypass supplies the data.
  - Index 0 is never pending.
- Undefined: no mask and no hazard stalling; in_ready follows the base rule only.

Decomposition:
- Package alu_pkg:
  - ALUOp constants: ADD=000, SUB=001, AND=010, OR=011, SRL=100, SRA=101.
  - Default DATA_W/ADDR_W.
  - Immediate-extend helper function.
- One natural sub-module: grf.
  - Two combinational read ports with write-through bypass, one synchronous write port, r0 hardwired to zero, asynchronous active-low clear.
  - Handshake, immediate select and scoreboard stay in alu_operand_fetch.

Test Plan:
- Reset then read: hold reset=0 for 2 cycles, release; accept rs=3, rt=4, out_ready=1 -> next cycle out_valid=1, out_a=0, out_b=0.
- Write then read with bypass: wb_en=1, wb_addr=5, wb_data=32'h1234_5678 in the same cycle as accept rs=5 -> out_a=32'h1234_5678. Write wb_addr=0, data 32'hFFFF_FFFF, then read rs=0 -> out_a=0.
- Immediate extend: in_use_imm=1, in_imm=16'h8001, in_imm_sext=1 -> out_b=32'hFFFF_8001. Same with in_imm_sext=0 -> out_b=32'h0000_8001. Check in_aluop=3'b101 appears on out_aluop.
- Backpressure: out_ready=0 for 3 cycles after a bundle -> in_ready=0 and outputs stable. wb to the captured rs during the stall leaves out_a unchanged. out_ready=1 -> transfer, and a new accept proceeds the same cycle.
- Back-to-back streaming: in_valid=1 and out_ready=1 for 8 cycles with rs=1..8 -> 8 bundles in order, no bubbles, out_valid continuous.
- Scoreboard (macro defined): accept rd=7, then present rs=7 -> in_ready=0 until wb_en with wb_addr=7. In that wb cycle in_ready=1 and out_a=wb_data. Without the macro, in_ready stays 1 throughout.
